// File: rtl/hazard_stall_controller_pkg.sv
// Shared constants and types for the decode-stage hazard/stall controller.
package hazard_stall_controller_pkg;

    localparam logic [4:0] XZR_REG = 5'd31;

    localparam int unsigned DEF_BR_EX_STALLS  = 2;
    localparam int unsigned DEF_BR_MEM_STALLS = 1;
    localparam int unsigned DEF_LU_STALLS     = 1;

    typedef enum logic {
        StRun   = 1'b0,
        StStall = 1'b1
    } state_e;

    function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module hazard_stall_controller_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_clear,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_stall_controller.sv
// Decode-stage hazard detection: load-use and compare-and-branch operand stalls,
// IF/ID flush on taken branches, and saturating stall/flush performance counters.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int unsigned BR_EX_STALLS  = DEF_BR_EX_STALLS,
    parameter int unsigned BR_MEM_STALLS = DEF_BR_MEM_STALLS,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_cb_instr,
    input  logic             id_branch_taken,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_rd,
    output logic             stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] EX_N  = 2'(BR_EX_STALLS);
    localparam logic [1:0] MEM_N = 2'(BR_MEM_STALLS);
    localparam logic [1:0] LU_N  = 2'(DEF_LU_STALLS);

    state_e     r_state;
    state_e     w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;

    logic       w_lu_haz;
    logic       w_br_ex_haz;
    logic       w_br_mem_haz;
    logic [1:0] w_need;
    logic       w_stall;
    logic       w_flush;

    // XZR as a destination never produces a value, so it cannot be a hazard source.
    assign w_lu_haz     = id_valid & ex_memread & (ex_rd != XZR_REG)
                        & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign w_br_ex_haz  = id_valid & id_cb_instr & ex_regwrite & (ex_rd != XZR_REG)
                        & (ex_rd == id_rs2);
    assign w_br_mem_haz = id_valid & id_cb_instr & mem_regwrite & (mem_rd != XZR_REG)
                        & (mem_rd == id_rs2);

    always_comb begin
        w_need = 2'd0;
        if (w_lu_haz) begin
            w_need = LU_N;
        end
        if (w_br_mem_haz) begin
            w_need = max2(w_need, MEM_N);
        end
        if (w_br_ex_haz) begin
            w_need = max2(w_need, EX_N);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        unique case (r_state)
            StRun: begin
                if (w_need != 2'd0) begin
                    w_stall = 1'b1;
                    if (w_need > 2'd1) begin
                        w_state_nxt = StStall;
                        w_cnt_nxt   = w_need - 2'd1;
                    end
                end
            end
            StStall: begin
                w_stall   = 1'b1;
                w_cnt_nxt = r_cnt - 2'd1;
                if (r_cnt <= 2'd1) begin
                    w_state_nxt = StRun;
                    w_cnt_nxt   = 2'd0;
                end
            end
        endcase
        // Outputs must show the idle pattern for as long as reset is held.
        if (!reset) begin
            w_stall = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= StRun;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_flush     = reset & id_branch_taken & id_valid & ~w_stall;

    assign stall       = w_stall;
    assign pc_write    = ~w_stall;
    assign if_id_write = ~w_stall;
    assign if_id_flush = w_flush;

    hazard_stall_controller_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_inc   (w_stall),
        .i_clear (1'b0),
        .o_count (stall_count)
    );

    hazard_stall_controller_sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_inc   (w_flush),
        .i_clear (1'b0),
        .o_count (flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed scenarios plus randomized traffic against
// a cycle-level model built from the hazard and stall-length rules.
module tb_hazard_stall_controller;

    localparam int unsigned EXS  = 2;
    localparam int unsigned MEMS = 1;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clock;
    logic          reset;
    logic          id_valid;
    logic [4:0]    id_rs1;
    logic [4:0]    id_rs2;
    logic          id_cb_instr;
    logic          id_branch_taken;
    logic          ex_memread;
    logic          ex_regwrite;
    logic [4:0]    ex_rd;
    logic          mem_regwrite;
    logic [4:0]    mem_rd;
    logic          stall;
    logic          pc_write;
    logic          if_id_write;
    logic          if_id_flush;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    int checks = 0;
    int errors = 0;

    // Model state: stall cycles still owed after the current one, and counter values.
    int m_rem   = 0;
    int m_scnt  = 0;
    int m_fcnt  = 0;

    hazard_stall_controller #(
        .BR_EX_STALLS  (EXS),
        .BR_MEM_STALLS (MEMS),
        .CNT_W         (CW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_cb_instr     (id_cb_instr),
        .id_branch_taken (id_branch_taken),
        .ex_memread      (ex_memread),
        .ex_regwrite     (ex_regwrite),
        .ex_rd           (ex_rd),
        .mem_regwrite    (mem_regwrite),
        .mem_rd          (mem_rd),
        .stall           (stall),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int need_len();
        int n;
        n = 0;
        if (!id_valid) return 0;
        if (ex_memread && ex_rd != 31 && (ex_rd == id_rs1 || ex_rd == id_rs2)) n = 1;
        if (id_cb_instr && mem_regwrite && mem_rd != 31 && mem_rd == id_rs2 && MEMS > n)
            n = MEMS;
        if (id_cb_instr && ex_regwrite && ex_rd != 31 && ex_rd == id_rs2 && EXS > n)
            n = EXS;
        return n;
    endfunction

    function automatic int exp_stall();
        if (!reset) return 0;
        if (m_rem > 0) return 1;
        return (need_len() > 0) ? 1 : 0;
    endfunction

    function automatic int exp_flush();
        if (!reset) return 0;
        return (id_branch_taken && id_valid && exp_stall() == 0) ? 1 : 0;
    endfunction

    // Compare on the falling edge, advance the model on the rising edge.
    initial begin
        int s;
        int f;
        forever begin
            @(negedge clock);
            s = exp_stall();
            f = exp_flush();
            chk("stall", int'(stall), s);
            chk("pc_write", int'(pc_write), 1 - s);
            chk("if_id_write", int'(if_id_write), 1 - s);
            chk("if_id_flush", int'(if_id_flush), f);
            chk("stall_count", int'(stall_count), reset ? m_scnt : 0);
            chk("flush_count", int'(flush_count), reset ? m_fcnt : 0);
            @(posedge clock);
            if (!reset) begin
                m_rem  = 0;
                m_scnt = 0;
                m_fcnt = 0;
            end else begin
                s = exp_stall();
                f = exp_flush();
                if (m_rem > 0) m_rem--;
                else if (need_len() > 0) m_rem = need_len() - 1;
                if (s == 1 && m_scnt < CMAX) m_scnt++;
                if (f == 1 && m_fcnt < CMAX) m_fcnt++;
            end
        end
    end

    task automatic clear_inputs();
        id_valid        = 1'b0;
        id_rs1          = 5'd0;
        id_rs2          = 5'd0;
        id_cb_instr     = 1'b0;
        id_branch_taken = 1'b0;
        ex_memread      = 1'b0;
        ex_regwrite     = 1'b0;
        ex_rd           = 5'd0;
        mem_regwrite    = 1'b0;
        mem_rd          = 5'd0;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        clear_inputs();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4:0] rreg();
        if ($urandom_range(0, 4) == 0) return 5'd31;
        return 5'($urandom_range(0, 3));
    endfunction

    initial begin
        reset = 1'b0;
        clear_inputs();
        #2;
        chk("reset_stall", int'(stall), 0);
        chk("reset_pc_write", int'(pc_write), 1);
        chk("reset_stall_count", int'(stall_count), 0);
        do_reset();

        // Load-use: one bubble.
        ex_memread = 1'b1; ex_rd = 5'd1; id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2;
        #1;
        chk("lu_stall", int'(stall), 1);
        chk("lu_pc_write", int'(pc_write), 0);
        chk("lu_if_id_write", int'(if_id_write), 0);
        next_cycle();
        clear_inputs();
        #1;
        chk("lu_release", int'(stall), 0);
        chk("lu_stall_count", int'(stall_count), 1);

        // CBZ against EX producer: two bubbles, taken branch ignored while stalled.
        do_reset();
        ex_regwrite = 1'b1; ex_rd = 5'd3; id_cb_instr = 1'b1; id_rs2 = 5'd3; id_valid = 1'b1;
        #1;
        chk("brex_stall0", int'(stall), 1);
        next_cycle();
        id_branch_taken = 1'b1;
        #1;
        chk("brex_stall1", int'(stall), 1);
        chk("brex_no_flush", int'(if_id_flush), 0);
        next_cycle();
        clear_inputs();
        #1;
        chk("brex_release", int'(stall), 0);
        chk("brex_stall_count", int'(stall_count), 2);
        chk("brex_flush_count", int'(flush_count), 0);

        // CBZ against MEM producer, then XZR producer.
        do_reset();
        mem_regwrite = 1'b1; mem_rd = 5'd4; id_cb_instr = 1'b1; id_rs2 = 5'd4; id_valid = 1'b1;
        #1;
        chk("brmem_stall", int'(stall), 1);
        next_cycle();
        mem_rd = 5'd31; id_rs2 = 5'd31;
        #1;
        chk("brmem_xzr_stall", int'(stall), 0);
        chk("brmem_stall_count", int'(stall_count), 1);

        // Taken branch without hazard flushes; bubble in ID does not.
        do_reset();
        id_branch_taken = 1'b1; id_valid = 1'b1;
        #1;
        chk("flush_on", int'(if_id_flush), 1);
        chk("flush_pc_write", int'(pc_write), 1);
        chk("flush_stall", int'(stall), 0);
        next_cycle();
        id_valid = 1'b0;
        #1;
        chk("flush_invalid", int'(if_id_flush), 0);
        chk("flush_count1", int'(flush_count), 1);
        next_cycle();
        clear_inputs();
        #1;
        chk("flush_count_hold", int'(flush_count), 1);

        // Asynchronous reset in the middle of a two-cycle stall.
        do_reset();
        ex_regwrite = 1'b1; ex_rd = 5'd3; id_cb_instr = 1'b1; id_rs2 = 5'd3; id_valid = 1'b1;
        next_cycle();
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_stall", int'(stall), 0);
        chk("rst_mid_pc_write", int'(pc_write), 1);
        chk("rst_mid_if_id_write", int'(if_id_write), 1);
        chk("rst_mid_stall_count", int'(stall_count), 0);
        next_cycle();
        reset = 1'b1;
        clear_inputs();
        #1;
        chk("rst_after_stall", int'(stall), 0);
        next_cycle();
        #1;
        chk("rst_after_stall2", int'(stall), 0);
        chk("rst_after_count", int'(stall_count), 0);

        // Saturation: 20 consecutive stall cycles into a 4-bit counter.
        do_reset();
        ex_regwrite = 1'b1; ex_rd = 5'd3; id_cb_instr = 1'b1; id_rs2 = 5'd3; id_valid = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        chk("sat_stall_count", int'(stall_count), 15);
        chk("sat_still_stall", int'(stall), 1);
        clear_inputs();

        // Randomized traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            next_cycle();
            reset           = ($urandom_range(0, 99) != 0);
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rs1          = rreg();
            id_rs2          = rreg();
            id_cb_instr     = 1'($urandom_range(0, 1));
            id_branch_taken = ($urandom_range(0, 2) == 0);
            ex_memread      = ($urandom_range(0, 2) == 0);
            ex_regwrite     = 1'($urandom_range(0, 1));
            ex_rd           = rreg();
            mem_regwrite    = 1'($urandom_range(0, 1));
            mem_rd          = rreg();
        end
        next_cycle();
        reset = 1'b1;
        clear_inputs();
        repeat (3) @(posedge clock);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
